// File: rtl/fx_pkg.sv
// Shared definitions for the fixed-point arithmetic library.
// Holds the default Q16.16 format, the saturation limits and the divider state type.
package fx_pkg;

   localparam int FX_WIDTH = 32;
   localparam int FX_QINT  = 16;
   localparam int FX_QFRAC = FX_WIDTH - FX_QINT;

   localparam logic [FX_WIDTH-1:0] FX_MAX = {1'b0, {(FX_WIDTH-1){1'b1}}};
   localparam logic [FX_WIDTH-1:0] FX_MIN = {1'b1, {(FX_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fx_state_e;

endpackage

// File: rtl/fx_div_seq.sv
// Sequential signed fixed-point divider: result = (a << QFRAC) / b.
// Restoring division, one quotient bit per cycle, truncated toward zero and saturated.
module fx_div_seq
   import fx_pkg::*;
#(
   parameter int WIDTH = FX_WIDTH,
   parameter int QINT  = FX_QINT,
   parameter int QFRAC = WIDTH - QINT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [WIDTH-1:0] result,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int              QW       = WIDTH + QFRAC;
   localparam int              CW       = $clog2(QW);
   localparam logic [CW-1:0]   LAST_CNT = CW'(QW - 1);
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

   fx_state_e        state_r;
   logic             sign_r;
   logic [WIDTH-1:0] mag_b_r;
   logic [QW-1:0]    dvd_r;
   logic [WIDTH:0]   rem_r;
   logic [QW-2:0]    quo_r;
   logic [CW-1:0]    count_r;

   logic [WIDTH-1:0] abs_a_s;
   logic [WIDTH-1:0] abs_b_s;
   logic [WIDTH+1:0] rem_shift_s;
   logic [WIDTH+1:0] rem_sub_s;
   logic             q_bit_s;
   logic [WIDTH:0]   rem_nxt_s;
   logic [QW-1:0]    q_fin_s;
   logic             ovf_s;
   logic [WIDTH-1:0] sat_res_s;

   // Operand magnitudes, one restoring step, and saturation of the completed quotient
   always_comb begin
      abs_a_s     = a[WIDTH-1] ? (~a + ONE_W) : a;
      abs_b_s     = b[WIDTH-1] ? (~b + ONE_W) : b;
      rem_shift_s = {rem_r, dvd_r[QW-1]};
      rem_sub_s   = rem_shift_s - {2'b00, mag_b_r};
      // The remainder stays below 2*mag_b, so the top bit of the difference is the borrow
      q_bit_s     = ~rem_sub_s[WIDTH+1];
      if (q_bit_s) begin
         rem_nxt_s = rem_sub_s[WIDTH:0];
      end else begin
         rem_nxt_s = rem_shift_s[WIDTH:0];
      end
      q_fin_s = {quo_r, q_bit_s};
      if (!sign_r) begin
         ovf_s = |q_fin_s[QW-1:WIDTH-1];
         if (ovf_s) begin
            sat_res_s = SAT_MAX;
         end else begin
            sat_res_s = q_fin_s[WIDTH-1:0];
         end
      end else begin
         ovf_s = (|q_fin_s[QW-1:WIDTH]) | (q_fin_s[WIDTH-1] & (|q_fin_s[WIDTH-2:0]));
         if (ovf_s) begin
            sat_res_s = SAT_MIN;
         end else begin
            sat_res_s = ~q_fin_s[WIDTH-1:0] + ONE_W;
         end
      end
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         sign_r      <= 1'b0;
         mag_b_r     <= {WIDTH{1'b0}};
         dvd_r       <= {QW{1'b0}};
         rem_r       <= {(WIDTH+1){1'b0}};
         quo_r       <= {(QW-1){1'b0}};
         count_r     <= {CW{1'b0}};
         ready_in    <= 1'b1;
         valid_out   <= 1'b0;
         result      <= {WIDTH{1'b0}};
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_in <= 1'b1;
               if (valid_in && ready_in) begin
                  sign_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                  mag_b_r  <= abs_b_s;
                  dvd_r    <= {abs_a_s, {QFRAC{1'b0}}};
                  rem_r    <= {(WIDTH+1){1'b0}};
                  quo_r    <= {(QW-1){1'b0}};
                  count_r  <= {CW{1'b0}};
                  ready_in <= 1'b0;
                  if (b == {WIDTH{1'b0}}) begin
                     result      <= a[WIDTH-1] ? SAT_MIN : SAT_MAX;
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     state_r     <= DONE;
                  end else begin
                     div_by_zero <= 1'b0;
                     overflow    <= 1'b0;
                     state_r     <= CALC;
                  end
               end
            end
            CALC: begin
               dvd_r   <= {dvd_r[QW-2:0], 1'b0};
               rem_r   <= rem_nxt_s;
               quo_r   <= q_fin_s[QW-2:0];
               count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
               if (count_r == LAST_CNT) begin
                  result      <= sat_res_s;
                  overflow    <= ovf_s;
                  div_by_zero <= 1'b0;
                  valid_out   <= 1'b1;
                  state_r     <= DONE;
               end
            end
            DONE: begin
               // Divide-by-zero enters here with valid_out still low; raise it one edge later
               if (valid_out) begin
                  if (ready_out) begin
                     valid_out <= 1'b0;
                     ready_in  <= 1'b1;
                     state_r   <= IDLE;
                  end
               end else begin
                  valid_out <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               ready_in  <= 1'b1;
               valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fx_div_seq.sv
// Directed self-checking bench for fx_div_seq with the default Q16.16 format.
module tb_fx_div_seq;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        ready_in;
   logic [31:0] a;
   logic [31:0] b;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] result;
   logic        div_by_zero;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int lat;
   int seen;

   fx_div_seq dut (
      .clk         (clk),
      .rst         (rst),
      .valid_in    (valid_in),
      .ready_in    (ready_in),
      .a           (a),
      .b           (b),
      .valid_out   (valid_out),
      .ready_out   (ready_out),
      .result      (result),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present operands for one accept edge; returns at the negedge after that edge.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      a        = av;
      b        = bv;
      valid_in = 1'b1;
      cycle();
      valid_in = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!valid_out && n < 200) begin
         cycle();
         n++;
      end
   endtask

   task automatic release_op(input string tag);
      ready_out = 1'b1;
      cycle();
      ready_out = 1'b0;
      check({tag, "_vo_drop"}, {31'd0, valid_out}, 32'd0);
      check({tag, "_ready_in"}, {31'd0, ready_in}, 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_dz, input logic exp_ovf);
      int n;
      start_op(av, bv);
      wait_valid(n);
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      check({tag, "_res"}, result, exp_res);
      check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
      release_op(tag);
   endtask

   initial begin
      rst       = 1'b1;
      valid_in  = 1'b0;
      ready_out = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_vo", {31'd0, valid_out}, 32'd0);
      check("rst_res", result, 32'd0);
      check("rst_dz", {31'd0, div_by_zero}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready_in", {31'd0, ready_in}, 32'd1);

      do_op("q3_2",    32'h0003_0000, 32'h0002_0000, 48, 32'h0001_8000, 1'b0, 1'b0);
      do_op("qm1_3",   32'hFFFF_0000, 32'h0003_0000, 48, 32'hFFFF_AAAB, 1'b0, 1'b0);
      do_op("ovf_pos", 32'h7FFF_0000, 32'h0000_8000, 48, 32'h7FFF_FFFF, 1'b0, 1'b1);
      do_op("min_m1",  32'h8000_0000, 32'hFFFF_0000, 48, 32'h7FFF_FFFF, 1'b0, 1'b1);
      do_op("min_p1",  32'h8000_0000, 32'h0001_0000, 48, 32'h8000_0000, 1'b0, 1'b0);
      do_op("zero_m1", 32'h0000_0000, 32'hFFFF_0000, 48, 32'h0000_0000, 1'b0, 1'b0);
      do_op("dz_pos",  32'h0005_0000, 32'h0000_0000, 1,  32'h7FFF_FFFF, 1'b1, 1'b0);
      do_op("dz_neg",  32'hFFFB_0000, 32'h0000_0000, 1,  32'h8000_0000, 1'b1, 1'b0);

      // Backpressure with ignored valid_in pulses during CALC and DONE.
      start_op(32'h0001_0000, 32'hFFFC_0000);
      repeat (5) cycle();
      a        = 32'h0005_0000;
      b        = 32'h0000_0000;
      valid_in = 1'b1;
      cycle();
      check("bp_calc_ready_in", {31'd0, ready_in}, 32'd0);
      valid_in = 1'b0;
      repeat (4) cycle();
      wait_valid(lat);
      check("bp_lat", 32'(lat), 32'd38);
      check("bp_res", result, 32'hFFFF_C000);
      for (int i = 0; i < 10; i++) begin
         valid_in = (i == 3);
         cycle();
         check("bp_hold_vo", {31'd0, valid_out}, 32'd1);
         check("bp_hold_res", result, 32'hFFFF_C000);
         check("bp_hold_ready_in", {31'd0, ready_in}, 32'd0);
      end
      valid_in = 1'b0;
      check("bp_dz", {31'd0, div_by_zero}, 32'd0);
      check("bp_ovf", {31'd0, overflow}, 32'd0);
      release_op("bp");

      // Reset in the middle of a division, 20 CALC edges in.
      start_op(32'h0003_0000, 32'h0002_0000);
      repeat (20) cycle();
      check("mid_busy", {31'd0, ready_in}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_res", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_ready_in", {31'd0, ready_in}, 32'd1);
      check("mid_vo", {31'd0, valid_out}, 32'd0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (valid_out) seen++;
      end
      check("mid_no_output", 32'(seen), 32'd0);
      do_op("mid_fresh", 32'h0003_0000, 32'h0002_0000, 48, 32'h0001_8000, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fx_div_seq.md
Name: fx_div_seq

Overview:
- Sequential signed fixed-point divider: result = (a << QFRAC) / b.
- Computes the inverse operation of the pipelined fixed-point multiplier, using the same Q(QINT).(QFRAC) format.
- Used by the regression/LSM datapath wherever a normalisation or reciprocal is needed.
- Restoring division, one quotient bit per cycle, with valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 32: total fixed-point word width, signed two's complement.
- QINT, 16: integer bits, including sign.
- QFRAC, WIDTH-QINT: fractional bits.
- QW (localparam), WIDTH+QFRAC: number of quotient bits, which equals the number of iteration cycles.

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- valid_in, in, 1: operands a and b are valid.
- ready_in, out, 1: block can accept operands. High only in IDLE.
- a, in, WIDTH: signed dividend.
- b, in, WIDTH: signed divisor.
- valid_out, out, 1: result and flags are valid.
- ready_out, in, 1: downstream accepts the result.
- result, out, WIDTH: signed quotient, truncated toward zero and saturated.
- div_by_zero, out, 1: b was 0 for this result.
- overflow, out, 1: the true quotient did not fit in WIDTH and was saturated.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - ready_in=1 once reset is released; valid_out=0, result=0, div_by_zero=0, overflow=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the operation; no output is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready_in=1.
  - On valid_in && ready_in (the accept edge, t0), register:
    - sign_q = a[MSB] ^ b[MSB]
    - mag_a = |a| (WIDTH-bit unsigned; |MIN| fits)
    - mag_b = |b|
    - dividend shift register = mag_a << QFRAC (QW bits)
    - remainder = 0 (WIDTH+1 bits)
    - count = 0
  - If b==0: go to DONE, with result = (a[MSB] ? FX_MIN : FX_MAX), div_by_zero=1, overflow=0. valid_out is high from t0+1.
  - Otherwise go to CALC.
- CALC, once per cycle:
  - rem' = {rem, next dividend MSB}.
  - If rem' >= mag_b: rem = rem' - mag_b and quotient bit = 1.
  - Otherwise: rem = rem' and quotient bit = 0.
  - Quotient shifts in from the LSB.
  - count increments.
  - At the edge where count reaches QW-1 (the QW-th CALC edge, t0+QW):
    - Register the final result and flags.
    - Set valid_out=1 and go to DONE.
- Finalisation, with the QW-bit unsigned quotient q:
  - sign_q=0: if q > 2^(WIDTH-1)-1, then result=FX_MAX and overflow=1; else result=q.
  - sign_q=1: if q > 2^(WIDTH-1), then result=FX_MIN and overflow=1; else result=-q (two's complement, low WIDTH bits).
  - If the quotient is 0 with sign_q=1, result=0 (no negative zero issue).
  - Rounding is truncation toward zero on the magnitude.
- Latency: valid_out rises QW cycles after the accept edge (48 with the defaults). Divide-by-zero latency is 1 cycle.
- DONE:
  - valid_out=1; result and flags are held stable.
  - On valid_out && ready_out: valid_out drops next edge and state goes to IDLE.
  - No new accept occurs in the same edge. Throughput is 1 op per QW+2 cycles minimum.
- ready_in=0 in CALC and DONE; valid_in is ignored there (no queuing).
- Operands are captured only at the accept edge; later changes on a and b have no effect.

Decomposition:
- fx_pkg holds:
  - Default WIDTH/QINT/QFRAC localparams.
  - FX_MAX = {1'b0, {WIDTH-1{1'b1}}} and FX_MIN = {1'b1, {WIDTH-1{1'b0}}}.
  - The state enum type {IDLE, CALC, DONE}.
- The rest of the fixed-point library shares this package.
- No sub-module. The restoring compare/subtract step stays inline as combinational logic feeding the state register.

Test Plan:
- a=0x00030000 (3.0), b=0x00020000 (2.0) -> result=0x00018000 (1.5), flags 0, valid_out exactly 48 cycles after the accept edge.
- a=0xFFFF0000 (-1.0), b=0x00030000 (3.0) -> result=0xFFFFAAAB (magnitude 0x5555 truncated), flags 0.
- a=0x7FFF0000 (32767.0), b=0x00008000 (0.5) -> result=0x7FFFFFFF, overflow=1. Separately, a=0x80000000, b=0xFFFF0000 (-1.0) -> 0x7FFFFFFF, overflow=1.
- Divide by zero:
  - a=0x00050000, b=0 -> result=0x7FFFFFFF, div_by_zero=1, valid_out at t0+1.
  - a=0xFFFB0000, b=0 -> 0x80000000, div_by_zero=1.
- Backpressure: hold ready_out=0 for 10 cycles after valid_out. Result and flags stay stable and ready_in stays 0. A valid_in pulse during CALC/DONE is not accepted. Raising ready_out returns the block to IDLE, and ready_in=1 on the next cycle.
- Reset mid-op: assert rst at count=20. ready_in=1 and valid_out=0 after release. A fresh 3.0/2.0 operation then completes correctly with 0x00018000.
